// File: rtl/lsu_mem_port_if.sv
// ============================================================================
//  Module      : lsu_mem_port_if
//  Description : Bundles the pipeline request/response channel and the data
//                memory channel of the load/store unit. The slave modport is
//                the LSU view; the master modport is the pipeline/memory view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_mem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Pipeline request channel
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_load;
    logic                  i_req_store;
    logic [1:0]            i_req_size;
    logic                  i_req_unsigned;
    logic [ADDR_W-1:0]     i_req_addr;
    logic [DATA_W-1:0]     i_req_wdata;
    // Pipeline response channel
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_W-1:0]     o_rsp_rdata;
    logic                  o_rsp_trap;
    // Data memory channel
    logic                  o_mem_valid;
    logic                  i_mem_ready;
    logic [ADDR_W-1:0]     o_mem_addr;
    logic                  o_mem_ren;
    logic                  o_mem_wen;
    logic [DATA_W-1:0]     o_mem_wdata;
    logic [DATA_W/8-1:0]   o_mem_mask;
    logic                  i_mem_rvalid;
    logic [DATA_W-1:0]     i_mem_rdata;

    modport slave (
        input  i_req_valid, i_req_load, i_req_store, i_req_size,
               i_req_unsigned, i_req_addr, i_req_wdata,
        output o_req_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_trap,
        input  i_rsp_ready,
        output o_mem_valid, o_mem_addr, o_mem_ren, o_mem_wen,
               o_mem_wdata, o_mem_mask,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata
    );

    modport master (
        output i_req_valid, i_req_load, i_req_store, i_req_size,
               i_req_unsigned, i_req_addr, i_req_wdata,
        input  o_req_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_trap,
        output i_rsp_ready,
        input  o_mem_valid, o_mem_addr, o_mem_ren, o_mem_wen,
               o_mem_wdata, o_mem_mask,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_port.sv
// ============================================================================
//  Module      : lsu_mem_port
//  Description : Load/store unit port to a variable-latency data memory.
//                Aligns addresses, builds byte masks, shifts store data,
//                extends load data and traps misaligned/illegal accesses.
//                One access in flight at a time.
//                Optional macro LSU_TIMEOUT_EN: trap a read/write that gets
//                no i_mem_rvalid within TIMEOUT_CYCLES cycles of WAIT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_port #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    lsu_mem_port_if.slave    bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(MASK_W);

    // Reject parameter sets the datapath is not built for
    generate
        if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("lsu_mem_port: DATA_W must be 32 or 64 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q;
    logic                req_ready_q;
    logic                load_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [OFF_W-1:0]    off_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_trap_q;
    logic                mem_valid_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_ren_q;
    logic                mem_wen_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [MASK_W-1:0]   mem_mask_q;
`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q;
`endif

    logic [OFF_W-1:0]    w_off;
    logic [3:0]          w_bytes;
    logic [OFF_W-1:0]    w_align_mask;
    logic [MASK_W-1:0]   w_lane_mask;
    logic                w_illegal;
    logic [DATA_W-1:0]   w_wdata_sh;
    logic [ADDR_W-1:0]   w_addr_al;
    logic [DATA_W-1:0]   w_rd_sh;
    logic [DATA_W-1:0]   w_load_ext;

    // Request decode: lane offset, byte mask, legality and store-data shift
    always_comb begin
        w_off        = bus.i_req_addr[OFF_W-1:0];
        w_bytes      = 4'd1 << bus.i_req_size;
        w_align_mask = OFF_W'(w_bytes - 4'd1);
        case (bus.i_req_size)
            2'd0:    w_lane_mask = MASK_W'(8'h01);
            2'd1:    w_lane_mask = MASK_W'(8'h03);
            2'd2:    w_lane_mask = MASK_W'(8'h0F);
            default: w_lane_mask = MASK_W'(8'hFF);
        endcase
        w_lane_mask = w_lane_mask << w_off;
        w_illegal   = (bus.i_req_load == bus.i_req_store)
                   || (DATA_W == 32 && bus.i_req_size == 2'd3)
                   || ((w_off & w_align_mask) != '0);
        w_wdata_sh  = bus.i_req_wdata << {w_off, 3'b000};
        w_addr_al   = {bus.i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    // Load return path: move the addressed lanes down, then extend
    always_comb begin
        w_rd_sh = bus.i_mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0: begin
                if (uns_q) w_load_ext = DATA_W'(w_rd_sh[7:0]);
                else       w_load_ext = DATA_W'($signed(w_rd_sh[7:0]));
            end
            2'd1: begin
                if (uns_q) w_load_ext = DATA_W'(w_rd_sh[15:0]);
                else       w_load_ext = DATA_W'($signed(w_rd_sh[15:0]));
            end
            2'd2: begin
                if (uns_q) w_load_ext = DATA_W'(w_rd_sh[31:0]);
                else       w_load_ext = DATA_W'($signed(w_rd_sh[31:0]));
            end
            default: w_load_ext = w_rd_sh;
        endcase
    end

    // Access sequencer; every output is a register so nothing glitches
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            load_q      <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_trap_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Ready rises one cycle after reset release or a response
                    req_ready_q <= 1'b1;
                    if (req_ready_q && bus.i_req_valid) begin
                        req_ready_q <= 1'b0;
                        load_q      <= bus.i_req_load;
                        size_q      <= bus.i_req_size;
                        uns_q       <= bus.i_req_unsigned;
                        off_q       <= w_off;
                        if (w_illegal) begin
                            rsp_valid_q <= 1'b1;
                            rsp_trap_q  <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= S_RESP;
                        end else begin
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= w_addr_al;
                            mem_ren_q   <= bus.i_req_load;
                            mem_wen_q   <= bus.i_req_store;
                            mem_wdata_q <= w_wdata_sh;
                            mem_mask_q  <= w_lane_mask;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.i_mem_ready) begin
                        mem_valid_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_ren_q   <= 1'b0;
                        mem_wen_q   <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_mask_q  <= '0;
`ifdef LSU_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.i_mem_rvalid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_trap_q  <= 1'b0;
                        rsp_rdata_q <= load_q ? w_load_ext : '0;
                        state_q     <= S_RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_trap_q  <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_trap_q  <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_trap  = rsp_trap_q;
    assign bus.o_mem_valid = mem_valid_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_ren   = mem_ren_q;
    assign bus.o_mem_wen   = mem_wen_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_mask  = mem_mask_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// ============================================================================
//  Module      : tb_lsu_mem_port
//  Description : Directed self-checking bench for lsu_mem_port (32-bit data).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_port;
    localparam int C_ADDR_W = 32;
    localparam int C_DATA_W = 32;

    logic i_clk;
    logic i_rst_n;
    int   n_checks;
    int   n_errors;

    lsu_mem_port_if #(.ADDR_W(C_ADDR_W), .DATA_W(C_DATA_W)) bus ();

    lsu_mem_port #(
        .ADDR_W         (C_ADDR_W),
        .DATA_W         (C_DATA_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Hard stop in case a sequence never completes
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, bus.o_req_ready, 0);
        check({tag, "_rsp_valid"}, bus.o_rsp_valid, 0);
        check({tag, "_rsp_rdata"}, bus.o_rsp_rdata, 0);
        check({tag, "_rsp_trap"},  bus.o_rsp_trap,  0);
        check({tag, "_mem_valid"}, bus.o_mem_valid, 0);
        check({tag, "_mem_addr"},  bus.o_mem_addr,  0);
        check({tag, "_mem_ren"},   bus.o_mem_ren,   0);
        check({tag, "_mem_wen"},   bus.o_mem_wen,   0);
        check({tag, "_mem_wdata"}, bus.o_mem_wdata, 0);
        check({tag, "_mem_mask"},  bus.o_mem_mask,  0);
    endtask

    task automatic drive_req(input logic ld, input logic st, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        bus.i_req_valid    = 1'b1;
        bus.i_req_load     = ld;
        bus.i_req_store    = st;
        bus.i_req_size     = sz;
        bus.i_req_unsigned = uns;
        bus.i_req_addr     = addr;
        bus.i_req_wdata    = wd;
    endtask

    task automatic rsp_handshake(input string tag);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        check({tag, "_rsp_done"},  bus.o_rsp_valid, 0);
        check({tag, "_ready_back"}, bus.o_req_ready, 1);
    endtask

    // Legal access at minimum latency: memory ready at once, rvalid one cycle later
    task automatic access(input string tag, input logic ld, input logic st,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd);
        check({tag, "_ready"}, bus.o_req_ready, 1);
        drive_req(ld, st, sz, uns, addr, wd);
        tick();                                  // accepted at edge N
        bus.i_req_valid = 1'b0;
        check({tag, "_memv_n1"}, bus.o_mem_valid, 1);
        check({tag, "_addr"},    bus.o_mem_addr,  exp_addr);
        check({tag, "_mask"},    bus.o_mem_mask,  exp_mask);
        check({tag, "_ren"},     bus.o_mem_ren,   ld);
        check({tag, "_wen"},     bus.o_mem_wen,   st);
        if (st) check({tag, "_wdata"}, bus.o_mem_wdata, exp_wd);
        check({tag, "_rspv_n1"}, bus.o_rsp_valid, 0);
        tick();                                  // N+2
        check({tag, "_memv_n2"}, bus.o_mem_valid, 0);
        check({tag, "_rspv_n2"}, bus.o_rsp_valid, 0);
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = rd;
        tick();                                  // N+3
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 32'hDEAD_BEEF;
        check({tag, "_rspv_n3"}, bus.o_rsp_valid, 1);
        check({tag, "_rdata"},   bus.o_rsp_rdata, exp_rd);
        check({tag, "_trap"},    bus.o_rsp_trap,  0);
        rsp_handshake(tag);
    endtask

    task automatic trap_access(input string tag, input logic ld, input logic st,
                               input logic [1:0] sz, input logic [31:0] addr);
        check({tag, "_ready"}, bus.o_req_ready, 1);
        drive_req(ld, st, sz, 1'b0, addr, 32'h1111_2222);
        tick();
        bus.i_req_valid = 1'b0;
        check({tag, "_rspv_n1"}, bus.o_rsp_valid, 1);
        check({tag, "_trap"},    bus.o_rsp_trap,  1);
        check({tag, "_rdata"},   bus.o_rsp_rdata, 0);
        check({tag, "_memv"},    bus.o_mem_valid, 0);
        tick();
        check({tag, "_memv_hold"}, bus.o_mem_valid, 0);
        check({tag, "_rspv_hold"}, bus.o_rsp_valid, 1);
        rsp_handshake(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_rst_n  = 1'b0;
        bus.i_req_valid    = 1'b0;
        bus.i_req_load     = 1'b0;
        bus.i_req_store    = 1'b0;
        bus.i_req_size     = 2'd0;
        bus.i_req_unsigned = 1'b0;
        bus.i_req_addr     = '0;
        bus.i_req_wdata    = '0;
        bus.i_rsp_ready    = 1'b0;
        bus.i_mem_ready    = 1'b1;
        bus.i_mem_rvalid   = 1'b0;
        bus.i_mem_rdata    = '0;

        #12;
        check_all_zero("reset");
        #10 i_rst_n = 1'b1;
        tick();
        check("post_reset_ready", bus.o_req_ready, 1);

        // lw / lb / lbu / lh / lhu / sh / sb
        access("lw",  1, 0, 2'd2, 0, 32'h1000, 0, 32'h8000_00FF,
               32'h1000, 4'b1111, 0, 32'h8000_00FF);
        access("lb",  1, 0, 2'd0, 0, 32'h2003, 0, 32'h8000_0000,
               32'h2000, 4'b1000, 0, 32'hFFFF_FF80);
        access("lbu", 1, 0, 2'd0, 1, 32'h2003, 0, 32'h8000_0000,
               32'h2000, 4'b1000, 0, 32'h0000_0080);
        access("lh",  1, 0, 2'd1, 0, 32'h6002, 0, 32'h8001_0000,
               32'h6000, 4'b1100, 0, 32'hFFFF_8001);
        access("lhu", 1, 0, 2'd1, 1, 32'h6002, 0, 32'h8001_0000,
               32'h6000, 4'b1100, 0, 32'h0000_8001);
        access("sh",  0, 1, 2'd1, 0, 32'h3002, 32'h0000_BEEF, 32'h5555_5555,
               32'h3000, 4'b1100, 32'hBEEF_0000, 0);
        access("sb",  0, 1, 2'd0, 0, 32'h7001, 32'h0000_00A5, 32'h5555_5555,
               32'h7000, 4'b0010, 32'h0000_A500, 0);

        // Illegal requests
        trap_access("mis_lw",   1, 0, 2'd2, 32'h4002);
        trap_access("ld_st",    1, 1, 2'd2, 32'h4000);
        trap_access("no_op",    0, 0, 2'd2, 32'h4000);
        trap_access("dword32",  1, 0, 2'd3, 32'h4000);
        trap_access("mis_sh",   0, 1, 2'd1, 32'h4001);

        // Back-pressure on both channels
        bus.i_mem_ready = 1'b0;
        drive_req(1, 0, 2'd2, 0, 32'h5004, 0);
        tick();
        bus.i_req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("stall_memv",  bus.o_mem_valid, 1);
            check("stall_addr",  bus.o_mem_addr,  32'h5004);
            check("stall_mask",  bus.o_mem_mask,  4'b1111);
            check("stall_ren",   bus.o_mem_ren,   1);
            check("stall_ready", bus.o_req_ready, 0);
            if (i < 5) tick();
        end
        bus.i_mem_ready = 1'b1;
        tick();
        check("stall_wait_memv", bus.o_mem_valid, 0);
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h1234_5678;
        tick();
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("hold_rspv",  bus.o_rsp_valid, 1);
            check("hold_rdata", bus.o_rsp_rdata, 32'h1234_5678);
            check("hold_trap",  bus.o_rsp_trap,  0);
            check("hold_ready", bus.o_req_ready, 0);
            if (i < 3) tick();
        end
        rsp_handshake("hold");

        // Reset while waiting for read data; a late rvalid must be ignored
        drive_req(1, 0, 2'd2, 0, 32'h8000, 0);
        tick();
        bus.i_req_valid = 1'b0;
        tick();                                  // now in WAIT
        #2 i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        #3 i_rst_n = 1'b1;
        tick();
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hCAFE_F00D;
        check("rst_idle_ready", bus.o_req_ready, 1);
        tick();
        bus.i_mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_no_rsp",  bus.o_rsp_valid, 0);
            check("rst_no_memv", bus.o_mem_valid, 0);
            check("rst_rdata",   bus.o_rsp_rdata, 0);
            tick();
        end

`ifdef LSU_TIMEOUT_EN
        // No rvalid ever: trap exactly TIMEOUT_CYCLES (8) cycles into WAIT
        begin
            int waited;
            drive_req(1, 0, 2'd2, 0, 32'h9000, 0);
            tick();
            bus.i_req_valid = 1'b0;
            tick();                              // handshake edge -> WAIT
            waited = 0;
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (bus.o_rsp_valid) begin
                    waited = k;
                    break;
                end
            end
            check("to_cycles", waited, 8);
            check("to_trap",   bus.o_rsp_trap,  1);
            check("to_rdata",  bus.o_rsp_rdata, 0);
            rsp_handshake("to");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Parametrised load/store unit between the execute/memory stage and a realistic, variable-latency data memory.
- Replaces the combinational dmem port of the single-cycle hart with a valid/ready request channel and an rvalid response channel.
- Performs lane alignment, byte-mask generation, store-data shifting and load sign/zero extension.
- Raises a trap on misaligned or illegal accesses. Holds one access in flight at a time.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, memory word width in bits. Legal values are 32 and 64. Mask width is DATA_W/8.
- TIMEOUT_CYCLES, 64, maximum number of cycles to wait for i_mem_rvalid. Used only with LSU_TIMEOUT_EN.

Ports:
- i_clk  in  1  global clock.
- i_rst_n  in  1  reset. Asynchronous, active-low.
- i_req_valid  in  1  access request from the pipeline.
- o_req_ready  out  1  unit can accept a request (high only in IDLE).
- i_req_load  in  1  request is a load.
- i_req_store  in  1  request is a store.
- i_req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- i_req_unsigned  in  1  zero-extend the load result (lbu/lhu/lwu).
- i_req_addr  in  ADDR_W  byte address.
- i_req_wdata  in  DATA_W  store data, LSB-justified.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  pipeline consumes the response.
- o_rsp_rdata  out  DATA_W  extended load result; 0 for stores and traps.
- o_rsp_trap  out  1  access trapped (misaligned or illegal).
- o_mem_valid  out  1  memory request valid.
- i_mem_ready  in  1  memory accepts the request.
- o_mem_addr  out  ADDR_W  aligned address (low log2(DATA_W/8) bits zero).
- o_mem_ren  out  1  read request.
- o_mem_wen  out  1  write request. Never asserted together with o_mem_ren.
- o_mem_wdata  out  DATA_W  store data shifted into its byte lanes.
- o_mem_mask  out  DATA_W/8  byte-lane enables.
- i_mem_rvalid  in  1  read data valid, or write acknowledge.
- i_mem_rdata  in  DATA_W  read word.

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset (async assert, synchronous-safe release) forces state IDLE and clears all outputs to 0. A reset mid-access abandons the access; any late i_mem_rvalid arriving in IDLE is ignored.
- IDLE: o_req_ready=1. On i_req_valid, latch all request fields.
  - Legal request: go to REQ.
  - Illegal request: go directly to RESP with o_rsp_trap=1 and no memory access.
- Illegal means any of:
  - i_req_load and i_req_store both set, or neither set.
  - size 11 when DATA_W=32.
  - address offset (addr mod DATA_W/8) not a multiple of the access byte count. Misaligned accesses are never split.
- REQ: o_mem_valid=1 with registered addr/ren/wen/mask/wdata.
  - Hold all of them stable until i_mem_ready=1, then go to WAIT.
  - Memory may not assert i_mem_rvalid before the cycle after the request handshake.
- WAIT: on i_mem_rvalid, capture the extended rdata (loads only) and go to RESP.
- RESP: o_rsp_valid=1. Hold o_rsp_rdata and o_rsp_trap stable until i_rsp_ready, then go to IDLE.
  - A new request can be accepted on the cycle after the response handshake, not the same cycle.
- Mask: ((1<<bytes)-1) << offset.
- Store data: o_mem_wdata = i_req_wdata << (8*offset).
- Load data: shift i_mem_rdata right by 8*offset, then sign- or zero-extend from 8/16/32 bits to DATA_W. A dword load is not extended.
- Minimum latency with i_mem_ready=1 and rvalid at the earliest legal cycle:
  - request accepted at cycle N, o_mem_valid at N+1, rvalid at N+2, o_rsp_valid at N+3.
- Trap responses: o_rsp_valid at N+1.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With the macro defined: a counter resets on entering WAIT and increments each cycle in WAIT. When it reaches TIMEOUT_CYCLES without i_mem_rvalid, go to RESP with o_rsp_trap=1 and o_rsp_rdata=0.
- Without the macro: WAIT waits indefinitely; no counter logic is synthesised.

Test Plan:
- lw at 0x1000, memory word 0x8000_00FF, ready=1, rvalid 1 cycle later -> o_mem_addr=0x1000, mask=1111, o_rsp_valid at N+3, rdata=0x8000_00FF, trap=0.
- lb at 0x2003, rdata 0x8000_0000, then lbu at the same address -> mask=1000; lb result 0xFFFF_FF80, lbu result 0x0000_0080.
- sh at 0x3002, wdata 0x0000_BEEF -> o_mem_addr=0x3000, wen=1, ren=0, mask=1100, o_mem_wdata=0xBEEF_0000; response rdata=0, trap=0.
- lw at 0x4002, and a request with load=store=1 -> no o_mem_valid ever; o_rsp_valid at N+1 with trap=1.
- i_mem_ready held low 5 cycles, then i_rsp_ready held low 3 cycles -> mem outputs stable throughout REQ, rsp outputs stable throughout RESP, o_req_ready=0 until the cycle after the response handshake.
- Reset asserted in WAIT, rvalid pulsed after release -> all outputs 0, state IDLE, no response. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, no rvalid -> trap response after exactly 8 WAIT cycles.
